// File: rtl/wash_cycle_ctrl_if.sv
// Bundles the wash controller's control inputs and panel outputs.
// The master side drives tick/start/settings; the slave side is the controller.
interface wash_cycle_ctrl_if #(
  parameter int TW = 8,
  parameter int WW = 3
);
  logic          tick;
  logic          start;
  logic [1:0]    mode;
  logic [WW-1:0] water_level;
  logic [TW-1:0] order_delay;

  logic          wash_light;
  logic          rinse_light;
  logic          spin_light;
  logic          inwater_light;
  logic          outwater_light;
  logic          run_light;
  logic          paused;
  logic          buzzer;
  logic [TW-1:0] remain_time;

  modport master (
    output tick, start, mode, water_level, order_delay,
    input  wash_light, rinse_light, spin_light, inwater_light, outwater_light,
    input  run_light, paused, buzzer, remain_time
  );

  modport slave (
    input  tick, start, mode, water_level, order_delay,
    output wash_light, rinse_light, spin_light, inwater_light, outwater_light,
    output run_light, paused, buzzer, remain_time
  );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: optional delayed start, wash/rinse/spin phases,
// pause/resume on the start button, and a timed end-of-cycle buzzer.
module wash_cycle_ctrl #(
  parameter int TW      = 8,
  parameter int WW      = 3,
  parameter int WASH_T  = 4,
  parameter int RINSE_T = 3,
  parameter int SPIN_T  = 2,
  parameter int BUZZ_T  = 3
) (
  input  logic             clk,
  input  logic             reset,
  wash_cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_FILL, S_AGITATE, S_DRAIN, S_SPIN, S_PAUSE, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE, PH_WASH, PH_RINSE, PH_SPIN
  } phase_t;

  state_t        r_state;
  state_t        r_saved;
  phase_t        r_phase;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] r_remain;
  logic [1:0]    r_mode;
  logic [WW-1:0] r_water;

  logic          r_washLight;
  logic          r_rinseLight;
  logic          r_spinLight;
  logic          r_inwaterLight;
  logic          r_outwaterLight;
  logic          r_runLight;
  logic          r_paused;
  logic          r_buzzer;

  state_t        w_nextState;
  state_t        w_nextSaved;
  phase_t        w_nextPhase;
  logic [TW-1:0] w_nextCnt;
  logic [TW-1:0] w_nextRemain;
  logic [1:0]    w_nextMode;
  logic [WW-1:0] w_nextWater;

  logic          w_tick;
  logic          w_cntLast;
  logic [TW-1:0] w_cntDec;
  logic [TW-1:0] w_remainDec;
  logic [WW-1:0] w_startWater;
  logic [TW-1:0] w_startWaterTw;
  logic [TW-1:0] w_washTotal;
  logic [TW-1:0] w_rinseTotal;
  logic [TW-1:0] w_total;
  logic [1:0]    w_selMode;
  logic [WW-1:0] w_selWater;
  state_t        w_firstState;
  phase_t        w_firstPhase;
  logic [TW-1:0] w_firstCnt;
  logic          w_nextRunning;

  // A start in the same cycle as a tick swallows the tick.
  assign w_tick      = bus.tick & ~bus.start;
  assign w_cntLast   = (r_cnt == TW'(1));
  assign w_cntDec    = r_cnt - TW'(1);
  assign w_remainDec = (r_remain == '0) ? '0 : r_remain - TW'(1);

  assign w_startWater   = (bus.water_level == '0) ? WW'(1) : bus.water_level;
  assign w_startWaterTw = TW'(w_startWater);
  assign w_washTotal    = (w_startWaterTw << 1) + TW'(WASH_T);
  assign w_rinseTotal   = (w_startWaterTw << 1) + TW'(RINSE_T);

  always_comb begin
    w_total = '0;
    case (bus.mode)
      2'd0:    w_total = w_washTotal + w_rinseTotal + TW'(SPIN_T);
      2'd1:    w_total = w_washTotal;
      2'd2:    w_total = w_rinseTotal + TW'(SPIN_T);
      default: w_total = TW'(SPIN_T);
    endcase
  end

  // From IDLE the first phase comes from the live inputs; from DELAY it comes from the latched copy.
  assign w_selMode  = (r_state == S_IDLE) ? bus.mode : r_mode;
  assign w_selWater = (r_state == S_IDLE) ? w_startWater : r_water;

  always_comb begin
    w_firstState = S_FILL;
    w_firstPhase = PH_WASH;
    w_firstCnt   = TW'(w_selWater);
    case (w_selMode)
      2'd0, 2'd1: begin
        w_firstState = S_FILL;
        w_firstPhase = PH_WASH;
        w_firstCnt   = TW'(w_selWater);
      end
      2'd2: begin
        w_firstState = S_FILL;
        w_firstPhase = PH_RINSE;
        w_firstCnt   = TW'(w_selWater);
      end
      default: begin
        w_firstState = S_SPIN;
        w_firstPhase = PH_SPIN;
        w_firstCnt   = TW'(SPIN_T);
      end
    endcase
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextSaved  = r_saved;
    w_nextPhase  = r_phase;
    w_nextCnt    = r_cnt;
    w_nextRemain = r_remain;
    w_nextMode   = r_mode;
    w_nextWater  = r_water;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nextMode   = bus.mode;
          w_nextWater  = w_startWater;
          w_nextRemain = w_total;
          if (bus.order_delay != '0) begin
            w_nextState = S_DELAY;
            w_nextCnt   = bus.order_delay;
          end else begin
            w_nextState = w_firstState;
            w_nextPhase = w_firstPhase;
            w_nextCnt   = w_firstCnt;
          end
        end
      end

      S_DELAY: begin
        if (bus.start) begin
          w_nextSaved = r_state;
          w_nextState = S_PAUSE;
        end else if (w_tick) begin
          if (w_cntLast) begin
            w_nextState = w_firstState;
            w_nextPhase = w_firstPhase;
            w_nextCnt   = w_firstCnt;
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      S_FILL: begin
        if (bus.start) begin
          w_nextSaved = r_state;
          w_nextState = S_PAUSE;
        end else if (w_tick) begin
          w_nextRemain = w_remainDec;
          if (w_cntLast) begin
            w_nextState = S_AGITATE;
            w_nextCnt   = (r_phase == PH_WASH) ? TW'(WASH_T) : TW'(RINSE_T);
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      S_AGITATE: begin
        if (bus.start) begin
          w_nextSaved = r_state;
          w_nextState = S_PAUSE;
        end else if (w_tick) begin
          w_nextRemain = w_remainDec;
          if (w_cntLast) begin
            w_nextState = S_DRAIN;
            w_nextCnt   = TW'(r_water);
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      // Only mode 0 chains wash into rinse; any rinse is always followed by spin.
      S_DRAIN: begin
        if (bus.start) begin
          w_nextSaved = r_state;
          w_nextState = S_PAUSE;
        end else if (w_tick) begin
          w_nextRemain = w_remainDec;
          if (w_cntLast) begin
            if (r_phase == PH_WASH && r_mode == 2'd0) begin
              w_nextState = S_FILL;
              w_nextPhase = PH_RINSE;
              w_nextCnt   = TW'(r_water);
            end else if (r_phase == PH_RINSE) begin
              w_nextState = S_SPIN;
              w_nextPhase = PH_SPIN;
              w_nextCnt   = TW'(SPIN_T);
            end else begin
              w_nextState  = S_DONE;
              w_nextPhase  = PH_NONE;
              w_nextCnt    = TW'(BUZZ_T);
              w_nextRemain = '0;
            end
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      S_SPIN: begin
        if (bus.start) begin
          w_nextSaved = r_state;
          w_nextState = S_PAUSE;
        end else if (w_tick) begin
          w_nextRemain = w_remainDec;
          if (w_cntLast) begin
            w_nextState  = S_DONE;
            w_nextPhase  = PH_NONE;
            w_nextCnt    = TW'(BUZZ_T);
            w_nextRemain = '0;
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      S_PAUSE: begin
        if (bus.start) begin
          w_nextState = r_saved;
        end
      end

      S_DONE: begin
        w_nextRemain = '0;
        if (bus.start) begin
          w_nextState = S_IDLE;
          w_nextCnt   = '0;
        end else if (w_tick) begin
          if (w_cntLast) begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = w_cntDec;
          end
        end
      end

      default: begin
        w_nextState = S_IDLE;
        w_nextPhase = PH_NONE;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign w_nextRunning = (w_nextState == S_DELAY)   || (w_nextState == S_FILL) ||
                         (w_nextState == S_AGITATE) || (w_nextState == S_DRAIN) ||
                         (w_nextState == S_SPIN);

  // Panel outputs are flopped from the next-state decode so they change with the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_saved         <= S_IDLE;
      r_phase         <= PH_NONE;
      r_cnt           <= '0;
      r_remain        <= '0;
      r_mode          <= '0;
      r_water         <= '0;
      r_washLight     <= 1'b0;
      r_rinseLight    <= 1'b0;
      r_spinLight     <= 1'b0;
      r_inwaterLight  <= 1'b0;
      r_outwaterLight <= 1'b0;
      r_runLight      <= 1'b0;
      r_paused        <= 1'b0;
      r_buzzer        <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_saved         <= w_nextSaved;
      r_phase         <= w_nextPhase;
      r_cnt           <= w_nextCnt;
      r_remain        <= w_nextRemain;
      r_mode          <= w_nextMode;
      r_water         <= w_nextWater;
      r_washLight     <= (w_nextPhase == PH_WASH);
      r_rinseLight    <= (w_nextPhase == PH_RINSE);
      r_spinLight     <= (w_nextPhase == PH_SPIN);
      r_inwaterLight  <= (w_nextState == S_FILL);
      r_outwaterLight <= (w_nextState == S_DRAIN);
      r_runLight      <= w_nextRunning;
      r_paused        <= (w_nextState == S_PAUSE);
      r_buzzer        <= (w_nextState == S_DONE);
    end
  end

  assign bus.wash_light     = r_washLight;
  assign bus.rinse_light    = r_rinseLight;
  assign bus.spin_light     = r_spinLight;
  assign bus.inwater_light  = r_inwaterLight;
  assign bus.outwater_light = r_outwaterLight;
  assign bus.run_light      = r_runLight;
  assign bus.paused         = r_paused;
  assign bus.buzzer         = r_buzzer;
  assign bus.remain_time    = r_remain;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl: drives start/tick pulses on the falling edge
// and compares the registered panel outputs against hand-computed values.
module tb_wash_cycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   numCompared   = 0;
  int   numMismatched = 0;

  wash_cycle_ctrl_if #(.TW(8), .WW(3)) bus ();

  wash_cycle_ctrl #(
    .TW(8), .WW(3), .WASH_T(4), .RINSE_T(3), .SPIN_T(2), .BUZZ_T(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One-cycle pulse on start/tick; returns on the falling edge after the sampling edge.
  task automatic applyStimulus(input logic s, input logic t);
    @(negedge clk);
    bus.start = s;
    bus.tick  = t;
    @(negedge clk);
    bus.start = 1'b0;
    bus.tick  = 1'b0;
  endtask

  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
  endtask

  task automatic applySettings(input logic [1:0] m, input logic [2:0] w, input logic [7:0] d);
    bus.mode        = m;
    bus.water_level = w;
    bus.order_delay = d;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    applySettings(2'd0, 3'd0, 8'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_remain", bus.remain_time, 0);
    checkOutput("rst_run", bus.run_light, 0);
    checkOutput("rst_buzzer", bus.buzzer, 0);
    checkOutput("rst_paused", bus.paused, 0);
    checkOutput("rst_wash", bus.wash_light, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_start_ignored_run", bus.run_light, 0);
    checkOutput("rst_start_ignored_remain", bus.remain_time, 0);
    reset = 1'b1;

    // Full cycle, mode 0, water 2: total 8 + 7 + 2 = 17.
    applySettings(2'd0, 3'd2, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m0_remain", bus.remain_time, 17);
    checkOutput("m0_inwater", bus.inwater_light, 1);
    checkOutput("m0_wash", bus.wash_light, 1);
    checkOutput("m0_run", bus.run_light, 1);
    applySettings(2'd3, 3'd7, 8'd9);
    applyTicks(2);
    checkOutput("m0_agit_inwater", bus.inwater_light, 0);
    checkOutput("m0_agit_remain", bus.remain_time, 15);
    applyTicks(4);
    checkOutput("m0_drain_out", bus.outwater_light, 1);
    checkOutput("m0_drain_remain", bus.remain_time, 11);
    applyTicks(2);
    checkOutput("m0_rinse_light", bus.rinse_light, 1);
    checkOutput("m0_rinse_wash", bus.wash_light, 0);
    checkOutput("m0_rinse_inwater", bus.inwater_light, 1);
    checkOutput("m0_rinse_remain", bus.remain_time, 9);
    applyTicks(7);
    checkOutput("m0_spin_light", bus.spin_light, 1);
    checkOutput("m0_spin_remain", bus.remain_time, 2);
    applyTicks(2);
    checkOutput("m0_done_buzzer", bus.buzzer, 1);
    checkOutput("m0_done_remain", bus.remain_time, 0);
    checkOutput("m0_done_run", bus.run_light, 0);
    checkOutput("m0_done_spin", bus.spin_light, 0);
    applyTicks(2);
    checkOutput("m0_buzz_hold", bus.buzzer, 1);
    applyTicks(1);
    checkOutput("m0_buzz_end", bus.buzzer, 0);
    applyTicks(2);
    checkOutput("m0_idle_run", bus.run_light, 0);
    checkOutput("m0_idle_remain", bus.remain_time, 0);

    // Delayed spin-only: remain_time holds through the delay.
    applySettings(2'd3, 3'd2, 8'd5);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m3_delay_run", bus.run_light, 1);
    checkOutput("m3_delay_remain", bus.remain_time, 2);
    checkOutput("m3_delay_spin", bus.spin_light, 0);
    applyTicks(4);
    checkOutput("m3_delay4_remain", bus.remain_time, 2);
    checkOutput("m3_delay4_spin", bus.spin_light, 0);
    applyTicks(1);
    checkOutput("m3_spin_light", bus.spin_light, 1);
    checkOutput("m3_spin_remain", bus.remain_time, 2);
    applyTicks(2);
    checkOutput("m3_done_buzzer", bus.buzzer, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m3_start_kills_buzzer", bus.buzzer, 0);
    checkOutput("m3_idle_run", bus.run_light, 0);

    // Wash only, water 0 treated as 1: total 6, pause/resume in AGITATE.
    applySettings(2'd1, 3'd0, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m1_remain", bus.remain_time, 6);
    applyTicks(3);
    checkOutput("m1_remain3", bus.remain_time, 3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m1_pause_paused", bus.paused, 1);
    checkOutput("m1_pause_run", bus.run_light, 0);
    checkOutput("m1_pause_wash", bus.wash_light, 1);
    checkOutput("m1_pause_remain", bus.remain_time, 3);
    applyTicks(10);
    checkOutput("m1_pause10_remain", bus.remain_time, 3);
    checkOutput("m1_pause10_paused", bus.paused, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m1_resume_paused", bus.paused, 0);
    checkOutput("m1_resume_run", bus.run_light, 1);
    applyTicks(2);
    checkOutput("m1_drain_out", bus.outwater_light, 1);
    checkOutput("m1_drain_remain", bus.remain_time, 1);
    applyTicks(1);
    checkOutput("m1_done_buzzer", bus.buzzer, 1);
    applyTicks(3);
    checkOutput("m1_idle_buzzer", bus.buzzer, 0);

    // Start and tick together in AGITATE: tick is discarded.
    applySettings(2'd1, 3'd1, 8'd0);
    applyStimulus(1'b1, 1'b0);
    applyTicks(1);
    checkOutput("st_agit_remain", bus.remain_time, 5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("st_pause_paused", bus.paused, 1);
    checkOutput("st_pause_remain", bus.remain_time, 5);
    applyStimulus(1'b1, 1'b0);
    applyTicks(3);
    checkOutput("st_agit_left_remain", bus.remain_time, 2);
    checkOutput("st_agit_left_out", bus.outwater_light, 0);
    applyTicks(1);
    checkOutput("st_drain_out", bus.outwater_light, 1);
    checkOutput("st_drain_remain", bus.remain_time, 1);

    // Reset aborts a rinse+spin cycle in DRAIN.
    applyReset();
    applySettings(2'd2, 3'd3, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m2_rinse_light", bus.rinse_light, 1);
    checkOutput("m2_remain", bus.remain_time, 11);
    applyTicks(6);
    checkOutput("m2_drain_out", bus.outwater_light, 1);
    checkOutput("m2_drain_remain", bus.remain_time, 5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("m2_rst_out", bus.outwater_light, 0);
    checkOutput("m2_rst_rinse", bus.rinse_light, 0);
    checkOutput("m2_rst_remain", bus.remain_time, 0);
    checkOutput("m2_rst_run", bus.run_light, 0);
    reset = 1'b1;
    applySettings(2'd3, 3'd3, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("m2_after_remain", bus.remain_time, 2);
    checkOutput("m2_after_spin", bus.spin_light, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
